match_tracker: RTL and testbench

Best-of-N match bookkeeping stage downstream of the reaction game core. It consumes each round's result (`winner`, `jump_start`, `round_over`, and the stopwatch BCD time) and keeps BCD win counts per player. It also keeps each player's best (lowest) reaction time, declares the match winner when a player reaches the target, and locks out further rounds until a new match starts. Its outputs feed the seven-segment encoders and display mux.

---
 rtl/match_tracker_if.sv | 28 ++
 rtl/match_tracker.sv | 123 ++++++++++++
 tb/tb_match_tracker.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/match_tracker_if.sv
// Round-result inputs and score/best-time outputs of the match tracker.
interface match_tracker_if;
  logic        new_match;
  logic        round_over;
  logic [1:0]  winner;
  logic        jump_start;
  logic [15:0] time_bcd;
  logic [7:0]  p1_wins_bcd;
  logic [7:0]  p2_wins_bcd;
  logic [15:0] p1_best_bcd;
  logic [15:0] p2_best_bcd;
  logic [1:0]  best_valid;
  logic        round_accepted;
  logic        match_over;
  logic [1:0]  match_winner;

  modport master (
    output new_match, round_over, winner, jump_start, time_bcd,
    input  p1_wins_bcd, p2_wins_bcd, p1_best_bcd, p2_best_bcd,
           best_valid, round_accepted, match_over, match_winner
  );

  modport slave (
    input  new_match, round_over, winner, jump_start, time_bcd,
    output p1_wins_bcd, p2_wins_bcd, p1_best_bcd, p2_best_bcd,
           best_valid, round_accepted, match_over, match_winner
  );
endinterface

// File: rtl/match_tracker.sv
// Best-of-N match bookkeeping: BCD win counts, best reaction times and
// match-over lockout, driven by rising edges of round_over.
module match_tracker #(
  parameter int unsigned WIN_TARGET = 5
) (
  input  logic            clk,
  input  logic            rst,
  match_tracker_if.slave  bus
);

  localparam logic [7:0]  TARGET_BCD = {4'(WIN_TARGET / 10), 4'(WIN_TARGET % 10)};
  localparam logic [15:0] BEST_INIT  = 16'h9999;

  typedef enum logic [1:0] {PLAY, CAPTURE, OVER} state_t;

  state_t      state;
  logic        rs_q;
  logic [1:0]  win_q;
  logic        js_q;
  logic [15:0] time_q;
  logic [7:0]  p1_wins, p2_wins;
  logic [15:0] p1_best, p2_best;
  logic [1:0]  best_valid;
  logic        round_accepted;
  logic        match_over;
  logic [1:0]  match_winner;
  logic        round_edge;
  logic [7:0]  p1_next, p2_next;
  logic        time_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign round_edge = bus.round_over & ~rs_q;
  assign p1_next    = bcd_inc(p1_wins);
  assign p2_next    = bcd_inc(p2_wins);
  assign time_ok    = (time_q[15:12] <= 4'd9) && (time_q[11:8] <= 4'd9) &&
                      (time_q[7:4]   <= 4'd9) && (time_q[3:0]  <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PLAY;
      rs_q           <= 1'b1;
      win_q          <= 2'b00;
      js_q           <= 1'b0;
      time_q         <= 16'h0000;
      p1_wins        <= 8'h00;
      p2_wins        <= 8'h00;
      p1_best        <= BEST_INIT;
      p2_best        <= BEST_INIT;
      best_valid     <= 2'b00;
      round_accepted <= 1'b0;
      match_over     <= 1'b0;
      match_winner   <= 2'b00;
    end else begin
      rs_q           <= bus.round_over;
      round_accepted <= 1'b0;
      if (bus.new_match) begin
        state        <= PLAY;
        p1_wins      <= 8'h00;
        p2_wins      <= 8'h00;
        p1_best      <= BEST_INIT;
        p2_best      <= BEST_INIT;
        best_valid   <= 2'b00;
        match_over   <= 1'b0;
        match_winner <= 2'b00;
      end else begin
        case (state)
          PLAY: begin
            if (round_edge) begin
              win_q  <= bus.winner;
              js_q   <= bus.jump_start;
              time_q <= bus.time_bcd;
              state  <= CAPTURE;
            end
          end
          CAPTURE: begin
            state <= PLAY;
            if (win_q == 2'b01) begin
              p1_wins        <= p1_next;
              round_accepted <= 1'b1;
              if (!js_q && time_ok && (time_q < p1_best || !best_valid[0])) begin
                p1_best       <= time_q;
                best_valid[0] <= 1'b1;
              end
              if (p1_next == TARGET_BCD) begin
                state        <= OVER;
                match_over   <= 1'b1;
                match_winner <= 2'b01;
              end
            end else if (win_q == 2'b10) begin
              p2_wins        <= p2_next;
              round_accepted <= 1'b1;
              if (!js_q && time_ok && (time_q < p2_best || !best_valid[1])) begin
                p2_best       <= time_q;
                best_valid[1] <= 1'b1;
              end
              if (p2_next == TARGET_BCD) begin
                state        <= OVER;
                match_over   <= 1'b1;
                match_winner <= 2'b10;
              end
            end
          end
          OVER:    state <= OVER;
          default: state <= PLAY;
        endcase
      end
    end
  end

  assign bus.p1_wins_bcd    = p1_wins;
  assign bus.p2_wins_bcd    = p2_wins;
  assign bus.p1_best_bcd    = p1_best;
  assign bus.p2_best_bcd    = p2_best;
  assign bus.best_valid     = best_valid;
  assign bus.round_accepted = round_accepted;
  assign bus.match_over     = match_over;
  assign bus.match_winner   = match_winner;

endmodule

// File: tb/tb_match_tracker.sv
// Scoreboard bench for match_tracker: directed plan items plus random rounds
// checked against an integer-arithmetic match model.
module tb_match_tracker;

  localparam int unsigned TARGET = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  match_tracker_if bus();
  match_tracker #(.WIN_TARGET(TARGET)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [1:0]  bv;
    logic        over;
    logic [1:0]  mw;
  } snap_t;

  snap_t exp_q[$];
  int vectors = 0;
  int errors  = 0;

  // reference model state
  int          m_w1, m_w2;
  logic [15:0] m_b1, m_b2;
  logic [1:0]  m_bv;
  bit          m_over;
  logic [1:0]  m_mw;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit digits_ok(input logic [15:0] t);
    for (int i = 0; i < 4; i++)
      if (((t >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.w1 = to_bcd(m_w1); s.w2 = to_bcd(m_w2);
    s.b1 = m_b1; s.b2 = m_b2; s.bv = m_bv;
    s.over = m_over; s.mw = m_mw;
    return s;
  endfunction

  task automatic model_clear();
    m_w1 = 0; m_w2 = 0; m_b1 = 16'h9999; m_b2 = 16'h9999;
    m_bv = 2'b00; m_over = 1'b0; m_mw = 2'b00;
  endtask

  task automatic model_round(input logic [1:0] w, input logic js,
                             input logic [15:0] t, output bit acc);
    acc = 1'b0;
    if (m_over || !(w == 2'b01 || w == 2'b10)) return;
    acc = 1'b1;
    if (w == 2'b01) begin
      m_w1++;
      if (!js && digits_ok(t) && (t < m_b1 || !m_bv[0])) begin m_b1 = t; m_bv[0] = 1'b1; end
      if (m_w1 == int'(TARGET)) begin m_over = 1'b1; m_mw = 2'b01; end
    end else begin
      m_w2++;
      if (!js && digits_ok(t) && (t < m_b2 || !m_bv[1])) begin m_b2 = t; m_bv[1] = 1'b1; end
      if (m_w2 == int'(TARGET)) begin m_over = 1'b1; m_mw = 2'b10; end
    end
    exp_q.push_back(model_snap());
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_snap(input string tag, input snap_t e);
    chk({tag, ".p1_wins"},      16'(bus.p1_wins_bcd),  16'(e.w1));
    chk({tag, ".p2_wins"},      16'(bus.p2_wins_bcd),  16'(e.w2));
    chk({tag, ".p1_best"},      bus.p1_best_bcd,       e.b1);
    chk({tag, ".p2_best"},      bus.p2_best_bcd,       e.b2);
    chk({tag, ".best_valid"},   16'(bus.best_valid),   16'(e.bv));
    chk({tag, ".match_over"},   16'(bus.match_over),   16'(e.over));
    chk({tag, ".match_winner"}, 16'(bus.match_winner), 16'(e.mw));
  endtask

  // monitor: every accepted-round pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.round_accepted === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL mon.unexpected_accept: got 1 expected 0 at %0t", $time);
      end else begin
        compare_snap("mon", exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input string tag);
    compare_snap(tag, model_snap());
    chk({tag, ".round_accepted"}, 16'(bus.round_accepted), 16'd0);
  endtask

  // one round: edge at the next posedge, inputs scrambled right after it
  task automatic do_round(input logic [1:0] w, input logic js, input logic [15:0] t);
    bit acc;
    @(negedge clk);
    bus.winner = w; bus.jump_start = js; bus.time_bcd = t; bus.round_over = 1'b1;
    model_round(w, js, t, acc);
    @(negedge clk);
    bus.round_over = 1'b0;
    bus.winner = 2'($urandom); bus.jump_start = 1'($urandom); bus.time_bcd = 16'($urandom);
    @(negedge clk);
    chk("latency.round_accepted", 16'(bus.round_accepted), 16'(acc));
    repeat (2) @(negedge clk);
    check_state("post_round");
  endtask

  task automatic pulse_new_match();
    @(negedge clk);
    bus.new_match = 1'b1;
    @(negedge clk);
    bus.new_match = 1'b0;
    model_clear();
  endtask

  function automatic logic [15:0] rand_time();
    if ($urandom_range(0, 4) == 0) return 16'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    rst = 1'b1;
    bus.new_match = 1'b0; bus.round_over = 1'b0; bus.winner = 2'b00;
    bus.jump_start = 1'b0; bus.time_bcd = 16'h0000;
    model_clear();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic P1 round and best-time handling
    do_round(2'b01, 1'b0, 16'h0237);
    do_round(2'b01, 1'b0, 16'h0300);
    do_round(2'b01, 1'b0, 16'h0199);
    do_round(2'b01, 1'b1, 16'h0001);
    do_round(2'b01, 1'b0, 16'h0A00);

    // ignored winner codes
    do_round(2'b00, 1'b0, 16'h0100);
    do_round(2'b11, 1'b0, 16'h0100);

    // BCD carry, target reached, then lockout
    pulse_new_match();
    check_state("new_match");
    for (int i = 0; i < int'(TARGET) + 1; i++)
      do_round(2'b10, 1'b0, rand_time());

    // new_match beats a simultaneous round edge; held level needs a fresh edge
    @(negedge clk);
    bus.new_match = 1'b1; bus.round_over = 1'b1;
    bus.winner = 2'b01; bus.jump_start = 1'b0; bus.time_bcd = 16'h0111;
    @(negedge clk);
    bus.new_match = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_state("nm_priority");
    bus.round_over = 1'b0;
    do_round(2'b01, 1'b0, 16'h0222);

    // reset while in CAPTURE loses the latched round
    @(negedge clk);
    bus.winner = 2'b10; bus.jump_start = 1'b0; bus.time_bcd = 16'h0050; bus.round_over = 1'b1;
    @(negedge clk);
    rst = 1'b1; bus.round_over = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_state("rst_capture");

    // round_over held high through reset release
    @(negedge clk);
    rst = 1'b1; bus.round_over = 1'b1; bus.winner = 2'b01;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_state("rst_level_high");
    bus.round_over = 1'b0;

    // randomized rounds, restarting the match whenever it is decided
    for (int i = 0; i < 60; i++) begin
      if (m_over && $urandom_range(0, 1) == 1) pulse_new_match();
      do_round(2'($urandom), ($urandom_range(0, 5) == 0), rand_time());
    end

    repeat (3) @(negedge clk);
    chk("scoreboard.drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
